// File: rtl/riscv_soft_fetch_pkg.sv
// Shared definitions for the riscv_soft fetch stage: FSM encodings, default reset vector, NOP word.
// No logic of its own; latency n/a.
// Backpressure n/a.
package riscv_soft_fetch_pkg;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0200;
  localparam logic [31:0] NOP_INST             = 32'h0000_0013;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_REQ      = 3'd1,
    ST_WAIT     = 3'd2,
    ST_DRAIN    = 3'd3,
    ST_MISALIGN = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/riscv_soft_fetch_buf.sv
// Single-entry output buffer holding one fetched instruction until execute takes it.
// Latency: load visible on outputs one cycle after the load edge.
// Backpressure: entry held while not consumed; load wins over squash, squash/consume clear it.
module riscv_soft_fetch_buf #(
  parameter int XPR_LEN = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [31:0]        load_data,
  input  logic [XPR_LEN-1:0] load_pc,
  input  logic               load_misalign,
  input  logic               squash,
  input  logic               consume,
  output logic               valid,
  output logic [31:0]        data,
  output logic [XPR_LEN-1:0] pc,
  output logic [XPR_LEN-1:0] pc_plus_4,
  output logic               misalign
);

  // Buffer register: load a new entry, otherwise drop it on squash or consume.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid     <= 1'b0;
      data      <= 32'h0;
      pc        <= '0;
      pc_plus_4 <= XPR_LEN'(4);
      misalign  <= 1'b0;
    end else if (load) begin
      valid     <= 1'b1;
      data      <= load_data;
      pc        <= load_pc;
      pc_plus_4 <= load_pc + XPR_LEN'(4);
      misalign  <= load_misalign;
    end else if (squash || consume) begin
      valid     <= 1'b0;
    end
  end

endmodule

// File: rtl/riscv_soft_fetch.sv
// Fetch stage: owns fetch PC, one outstanding I-cache request, single-entry output buffer.
// Latency: request to buffered instruction is cache latency + 1 cycle (2 cycles/insn with a 1-cycle cache).
// Backpressure: no request issues unless the buffer is empty or being consumed; optional macro RISCV_SOFT_FETCH_MISALIGN_EN.
module riscv_soft_fetch
  import riscv_soft_fetch_pkg::*;
#(
  parameter int                 XPR_LEN      = 32,
  parameter logic [XPR_LEN-1:0] RESET_VECTOR = XPR_LEN'(DEFAULT_RESET_VECTOR)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_cache_req_ready,
  output logic               i_cache_req_valid,
  output logic [XPR_LEN-1:0] i_cache_req_addr,
  input  logic               i_cache_resp_valid,
  input  logic [31:0]        i_cache_resp_data,
  input  logic               redirect_valid,
  input  logic [XPR_LEN-1:0] redirect_PC,
  input  logic               stall_IF,
  output logic               inst_valid,
  output logic [31:0]        inst_data,
  output logic [XPR_LEN-1:0] inst_PC,
  output logic [XPR_LEN-1:0] inst_PC_plus_4,
  output logic               inst_misalign
);

  fetch_state_t       state, state_nxt;
  logic [XPR_LEN-1:0] fetch_pc;
  logic               consume, slot_free, req_fire;
  logic               redir_misalign, resp_load;
  logic               buf_load;
  logic [31:0]        buf_data;
  logic [XPR_LEN-1:0] buf_pc;

  assign consume   = inst_valid && !stall_IF;
  assign slot_free = !inst_valid || consume;

  assign i_cache_req_valid = (state == ST_REQ) && slot_free;
  assign i_cache_req_addr  = fetch_pc;
  assign req_fire          = i_cache_req_valid && i_cache_req_ready;

  // A normal response is only kept when no redirect squashes it in the same cycle.
  assign resp_load = !redirect_valid && (state == ST_WAIT) && i_cache_resp_valid;

`ifdef RISCV_SOFT_FETCH_MISALIGN_EN
  logic pend;

  assign redir_misalign = redirect_valid && (redirect_PC[1:0] != 2'b00);

  // Track the outstanding request so leaving MISALIGN can still drain a late response.
  always_ff @(posedge clk) begin
    if (reset)                   pend <= 1'b0;
    else if (req_fire)           pend <= 1'b1;
    else if (i_cache_resp_valid) pend <= 1'b0;
  end
`else
  assign redir_misalign = 1'b0;
`endif

  // Misaligned redirect targets load a marked NOP instead of fetched data.
  assign buf_load = resp_load || redir_misalign;
  assign buf_data = redir_misalign ? NOP_INST : i_cache_resp_data;
  assign buf_pc   = redir_misalign ? redirect_PC : fetch_pc;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode; redirect outranks stall and same-cycle responses.
  always_comb begin
    state_nxt = state;
    if (redirect_valid) begin
      if (redir_misalign) begin
        state_nxt = ST_MISALIGN;
      end else begin
        case (state)
          ST_REQ:   state_nxt = req_fire ? ST_DRAIN : ST_REQ;
          ST_WAIT,
          ST_DRAIN: state_nxt = i_cache_resp_valid ? ST_REQ : ST_DRAIN;
`ifdef RISCV_SOFT_FETCH_MISALIGN_EN
          ST_MISALIGN: state_nxt = (pend && !i_cache_resp_valid) ? ST_DRAIN : ST_REQ;
`endif
          default:  state_nxt = ST_REQ;
        endcase
      end
    end else begin
      case (state)
        ST_IDLE:  state_nxt = ST_REQ;
        ST_REQ:   if (req_fire) state_nxt = ST_WAIT;
        ST_WAIT,
        ST_DRAIN: if (i_cache_resp_valid) state_nxt = ST_REQ;
        default:  state_nxt = state;
      endcase
    end
  end

  // Fetch PC: redirect target (word aligned) or advance past each kept response.
  always_ff @(posedge clk) begin
    if (reset)               fetch_pc <= RESET_VECTOR;
    else if (redirect_valid) fetch_pc <= {redirect_PC[XPR_LEN-1:2], 2'b00};
    else if (resp_load)      fetch_pc <= fetch_pc + XPR_LEN'(4);
  end

  riscv_soft_fetch_buf #(.XPR_LEN(XPR_LEN)) u_buf (
    .clk           (clk),
    .reset         (reset),
    .load          (buf_load),
    .load_data     (buf_data),
    .load_pc       (buf_pc),
    .load_misalign (redir_misalign),
    .squash        (redirect_valid),
    .consume       (consume),
    .valid         (inst_valid),
    .data          (inst_data),
    .pc            (inst_PC),
    .pc_plus_4     (inst_PC_plus_4),
    .misalign      (inst_misalign)
  );

endmodule

// File: tb/tb_riscv_soft_fetch.sv
// Self-checking bench for riscv_soft_fetch: directed latency/stall/redirect cases, then random traffic.
// Expected instruction stream comes from a program-order PC model; a cache model answers requests.
// Monitor pops expected entries whenever execute consumes an instruction.
module tb_riscv_soft_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_cache_req_ready;
  logic        i_cache_req_valid;
  logic [31:0] i_cache_req_addr;
  logic        i_cache_resp_valid;
  logic [31:0] i_cache_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_PC;
  logic        stall_IF;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_PC;
  logic [31:0] inst_PC_plus_4;
  logic        inst_misalign;

  always #5 clk = ~clk;

  riscv_soft_fetch dut (
    .clk                (clk),
    .reset              (reset),
    .i_cache_req_ready  (i_cache_req_ready),
    .i_cache_req_valid  (i_cache_req_valid),
    .i_cache_req_addr   (i_cache_req_addr),
    .i_cache_resp_valid (i_cache_resp_valid),
    .i_cache_resp_data  (i_cache_resp_data),
    .redirect_valid     (redirect_valid),
    .redirect_PC        (redirect_PC),
    .stall_IF           (stall_IF),
    .inst_valid         (inst_valid),
    .inst_data          (inst_data),
    .inst_PC            (inst_PC),
    .inst_PC_plus_4     (inst_PC_plus_4),
    .inst_misalign      (inst_misalign)
  );

  int n_vec = 0;
  int n_err = 0;
  int n_cons = 0;
  logic [31:0] exp_q[$];

  int          pct_ready, pct_stall, pct_redir, lat_min, lat_max;
  logic        rst_next;
  logic        force_redir;
  logic [31:0] force_target;

  logic        pend;
  logic [31:0] pend_addr;
  int          lat;
  logic        last_fire, last_resp;
  logic [31:0] last_addr;
  logic        prev_redir_plain;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0200) return 32'h0000_0093;
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    t = 32'h0000_1000 + ($urandom_range(0, 1023) << 2);
    if ($urandom_range(0, 15) == 0) t = 32'hFFFF_FFF8;
`ifndef RISCV_SOFT_FETCH_MISALIGN_EN
    t[1:0] = 2'($urandom_range(0, 3));
`endif
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    check(name, 32'(act), 32'(exp));
  endtask

  // One clock of stimulus: cache model update, input drive, handshake capture.
  task automatic step();
    logic [31:0] t;
    @(negedge clk);
    reset = rst_next;
    if (reset) begin
      pend = 1'b0;
    end else begin
      if (last_resp) pend = 1'b0;
      if (last_fire) begin
        check_bit("one_outstanding", pend, 1'b0);
        check("req_word_aligned", {30'b0, last_addr[1:0]}, 32'h0);
        pend      = 1'b1;
        pend_addr = last_addr;
        lat       = $urandom_range(lat_max, lat_min);
      end else if (pend && lat > 0) begin
        lat--;
      end
    end
    i_cache_resp_valid = !reset && pend && (lat == 0);
    i_cache_resp_data  = i_cache_resp_valid ? mem_word(pend_addr) : $urandom;
    i_cache_req_ready  = ($urandom_range(99, 0) < pct_ready);
    stall_IF           = ($urandom_range(99, 0) < pct_stall);
    if (force_redir || (!reset && $urandom_range(99, 0) < pct_redir)) begin
      t = force_redir ? force_target : rand_target();
      redirect_valid = 1'b1;
      redirect_PC    = t;
      exp_q.delete();
`ifdef RISCV_SOFT_FETCH_MISALIGN_EN
      exp_q.push_back(t);
`else
      exp_q.push_back({t[31:2], 2'b00});
`endif
    end else begin
      redirect_valid = 1'b0;
      redirect_PC    = $urandom;
    end
    force_redir = 1'b0;
    #1;
    last_fire = !reset && i_cache_req_valid && i_cache_req_ready;
    last_addr = i_cache_req_addr;
    last_resp = i_cache_resp_valid;
  endtask

  task automatic redirect_to(input logic [31:0] t);
    force_redir  = 1'b1;
    force_target = t;
    step();
  endtask

  // Monitor: compare every consumed instruction against the program-order model.
  always @(negedge clk) begin
    logic [31:0] e;
    #2;
    if (reset) begin
      prev_redir_plain = 1'b0;
    end else begin
      if (prev_redir_plain) check_bit("squash_after_redirect", inst_valid, 1'b0);
      if (inst_valid && !stall_IF && !redirect_valid) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_inst: got pc %h, expected none", inst_PC);
        end else begin
          e = exp_q.pop_front();
          n_cons++;
          check("inst_pc", inst_PC, e);
          check("inst_pc_plus_4", inst_PC_plus_4, e + 32'd4);
          if (e[1:0] != 2'b00) begin
            check("inst_data_nop", inst_data, 32'h0000_0013);
            check_bit("inst_misalign_set", inst_misalign, 1'b1);
          end else begin
            check("inst_data", inst_data, mem_word(e));
            check_bit("inst_misalign_clr", inst_misalign, 1'b0);
            exp_q.push_back(e + 32'd4);
          end
        end
      end
`ifdef RISCV_SOFT_FETCH_MISALIGN_EN
      prev_redir_plain = redirect_valid && (redirect_PC[1:0] == 2'b00);
`else
      prev_redir_plain = redirect_valid;
`endif
    end
  end

  initial begin
    int c0;
    reset = 1'b1; rst_next = 1'b1;
    i_cache_req_ready = 1'b0; i_cache_resp_valid = 1'b0; i_cache_resp_data = '0;
    redirect_valid = 1'b0; redirect_PC = '0; stall_IF = 1'b0;
    pct_ready = 100; pct_stall = 0; pct_redir = 0; lat_min = 0; lat_max = 0;
    force_redir = 1'b0; force_target = '0;
    pend = 1'b0; pend_addr = '0; lat = 0;
    last_fire = 1'b0; last_resp = 1'b0; last_addr = '0; prev_redir_plain = 1'b0;
    exp_q.push_back(32'h0000_0200);

    step(); step();
    check_bit("rst_req_valid", i_cache_req_valid, 1'b0);
    check("rst_req_addr", i_cache_req_addr, 32'h0000_0200);
    check_bit("rst_inst_valid", inst_valid, 1'b0);
    check("rst_inst_data", inst_data, 32'h0);
    check("rst_inst_pc", inst_PC, 32'h0);
    check("rst_inst_pc_plus_4", inst_PC_plus_4, 32'h4);
    check_bit("rst_inst_misalign", inst_misalign, 1'b0);

    // First fetch latency with a 1-cycle cache.
    rst_next = 1'b0;
    step(); check_bit("c0_req_valid", i_cache_req_valid, 1'b0);
    step(); check_bit("c1_req_valid", i_cache_req_valid, 1'b1);
            check("c1_req_addr", i_cache_req_addr, 32'h0000_0200);
    step(); check_bit("c2_inst_valid", inst_valid, 1'b0);
    step(); check_bit("c3_inst_valid", inst_valid, 1'b1);
            check("c3_inst_pc", inst_PC, 32'h0000_0200);
            check("c3_inst_data", inst_data, 32'h0000_0093);
            check("c3_inst_pc_plus_4", inst_PC_plus_4, 32'h0000_0204);
            check_bit("c3_req_valid", i_cache_req_valid, 1'b1);
            check("c3_req_addr", i_cache_req_addr, 32'h0000_0204);
    step();

    // Stall holds the buffer and blocks requests; release issues at once.
    pct_stall = 100;
    for (int i = 0; i < 5; i++) begin
      step();
      check_bit("stall_inst_valid", inst_valid, 1'b1);
      check("stall_inst_pc", inst_PC, 32'h0000_0204);
      check("stall_inst_data", inst_data, mem_word(32'h0000_0204));
      check_bit("stall_no_req", i_cache_req_valid, 1'b0);
    end
    pct_stall = 0;
    step(); check_bit("release_req_valid", i_cache_req_valid, 1'b1);
            check("release_req_addr", i_cache_req_addr, 32'h0000_0208);
    step();

    // Cache not ready: request held stable.
    pct_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_bit("notready_req_valid", i_cache_req_valid, 1'b1);
      check("notready_req_addr", i_cache_req_addr, 32'h0000_020C);
    end
    pct_ready = 100; lat_min = 2; lat_max = 2;
    step(); check("accept_req_addr", i_cache_req_addr, 32'h0000_020C);

    // Redirect while waiting; the late response must be drained.
    redirect_to(32'h0000_0400);
    lat_min = 0; lat_max = 0;
    step(); check_bit("drain_inst_valid", inst_valid, 1'b0);
            check_bit("drain_no_req", i_cache_req_valid, 1'b0);
    step(); check_bit("drain_resp_no_req", i_cache_req_valid, 1'b0);
    step(); check_bit("post_drain_req_valid", i_cache_req_valid, 1'b1);
            check("post_drain_req_addr", i_cache_req_addr, 32'h0000_0400);
    step();
    step(); check("redir_target_inst_pc", inst_PC, 32'h0000_0400);

    // Redirect coinciding with a response.
    redirect_to(32'h0000_0800);
    step(); check_bit("same_cycle_inst_valid", inst_valid, 1'b0);
            check_bit("same_cycle_req_valid", i_cache_req_valid, 1'b1);
            check("same_cycle_req_addr", i_cache_req_addr, 32'h0000_0800);

    // Random traffic.
    pct_ready = 70; pct_stall = 30; pct_redir = 6; lat_min = 0; lat_max = 3;
    repeat (3000) step();
    pct_ready = 100; pct_stall = 0; pct_redir = 0;
    repeat (20) step();
    c0 = n_cons;
    repeat (12) step();
    check_bit("forward_progress", n_cons > c0, 1'b1);

`ifdef RISCV_SOFT_FETCH_MISALIGN_EN
    pct_stall = 100;
    redirect_to(32'h0000_0402);
    step();
    check_bit("mis_inst_valid", inst_valid, 1'b1);
    check_bit("mis_flag", inst_misalign, 1'b1);
    check("mis_inst_data", inst_data, 32'h0000_0013);
    check("mis_inst_pc", inst_PC, 32'h0000_0402);
    pct_stall = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      check_bit("mis_no_req", i_cache_req_valid, 1'b0);
    end
    redirect_to(32'h0000_0500);
    c0 = n_cons;
    repeat (12) step();
    check_bit("mis_resume_progress", n_cons > c0, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
